alu_mul_seq: RTL and testbench

- Multi-cycle 4x4 unsigned shift-and-add multiplier controller that acts as the initiator for the 4-bit slice ALU.
- Owns the accumulator, multiplier and carry registers, and drives the ALU's operand, select, carry-in and shift-fill inputs.
- Samples the ALU result and carry each cycle.
- Lets the datapath reuse the one existing ALU for multiplication instead of adding a dedicated multiplier array.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 132 +++++++++++++
 tb/tb_alu_mul_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential multiplier and the 4-bit slice ALU it drives:
// ALU select/carry-in encodings, controller state enum and the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [3:0] SEL_XFER = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b0001;
    localparam logic [3:0] SEL_SHR  = 4'b1000;

    localparam logic C0_XFER = 1'b0;
    localparam logic C0_ADD  = 1'b0;
    localparam logic C0_SHR  = 1'b0;  // ALU ignores c0 for SHR; tie low

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 4x4 unsigned multiplier that time-shares the external slice ALU:
// one ADD/XFER cycle plus one SHR cycle per multiplier bit, then a DONE cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_s,
    output logic               alu_c0,
    output logic               alu_il,
    output logic               alu_ir,
    input  logic [WIDTH-1:0]   alu_f,
    input  logic               alu_c8
);

    if (WIDTH != 4) begin : g_width_check
        $error("alu_mul_seq: only WIDTH=4 is supported");
    end

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic                 r_c;
    logic [1:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_alu_a;
    logic [WIDTH-1:0]     w_alu_b;
    logic [3:0]           w_alu_s;
    logic                 w_alu_c0;
    logic                 w_alu_ir;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_s  = SEL_XFER;
        w_alu_c0 = C0_XFER;
        w_alu_ir = 1'b0;
        case (r_state)
            ADD: begin
                w_alu_a  = r_a;
                w_alu_b  = r_m;
                w_alu_s  = r_q[0] ? SEL_ADD : SEL_XFER;
                w_alu_c0 = r_q[0] ? C0_ADD  : C0_XFER;
            end
            SHIFT: begin
                w_alu_a  = r_a;
                w_alu_s  = SEL_SHR;
                w_alu_c0 = C0_SHR;
                w_alu_ir = r_c;
            end
            default: ;
        endcase
    end

    // done/busy are registered, so the done pulse shows one cycle after DONE; the IDLE
    // cycle carrying that pulse still counts as busy and refuses start.
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= 2'd0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !r_done) begin
                        r_m     <= mcand;
                        r_q     <= mplier;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ADD: begin
                    r_a     <= alu_f;
                    r_c     <= alu_c8;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_a     <= alu_f;
                    r_q     <= {r_a[0], r_q[WIDTH-1:1]};
                    r_c     <= 1'b0;
                    r_cnt   <= r_cnt + 2'd1;
                    r_state <= (r_cnt == 2'd3) ? DONE : ADD;
                end
                DONE: begin
                    r_product <= {r_a, r_q};
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign alu_a   = w_alu_a;
    assign alu_b   = w_alu_b;
    assign alu_s   = w_alu_s;
    assign alu_c0  = w_alu_c0;
    assign alu_il  = 1'b0;
    assign alu_ir  = w_alu_ir;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; a behavioural 4-bit slice ALU closes the loop.
module tb_alu_mul_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_c0;
    logic       alu_il;
    logic       alu_ir;
    logic [3:0] alu_f;
    logic       alu_c8;

    int checks = 0;
    int errors = 0;

    logic [3:0] seen_s [0:7];

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_c0  (alu_c0),
        .alu_il  (alu_il),
        .alu_ir  (alu_ir),
        .alu_f   (alu_f),
        .alu_c8  (alu_c8)
    );

    // Slice ALU model: only the encodings the multiplier uses
    always_comb begin
        logic [4:0] sum;
        sum    = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_c0};
        alu_f  = 4'd0;
        alu_c8 = 1'b0;
        case (alu_s)
            4'b0000: alu_f = alu_a;
            4'b0001: begin
                alu_f  = sum[3:0];
                alu_c8 = sum[4];
            end
            4'b1000: alu_f = {alu_ir, alu_a[3:1]};
            default: ;
        endcase
    end

    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input string name);
        int done_at;
        int pulses;
        done_at = -1;
        pulses  = 0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 8) seen_s[i] = alu_s;
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b want 1", name, busy);
                end
            end
            if (alu_il !== 1'b0 && i < 8) begin
                errors++;
                $display("FAIL %s alu_il: got %b want 0 (cycle %0d)", name, alu_il, i);
            end
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        checks++;
        if (done_at != 9) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d want 9", name, done_at);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d want 1", name, pulses);
        end
        checks++;
        if (product !== exp) begin
            errors++;
            $display("FAIL %s product: got %h want %h", name, product, exp);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = 4'd0;
        mplier = 4'd0;
        #3;
        checks++;
        if ({busy, done, product} !== 10'd0) begin
            errors++;
            $display("FAIL reset status: got busy=%b done=%b product=%h want 0", busy, done, product);
        end
        checks++;
        if ({alu_a, alu_b, alu_s, alu_c0, alu_il, alu_ir} !== 15'd0) begin
            errors++;
            $display("FAIL reset alu: got a=%h b=%h s=%h c0=%b il=%b ir=%b want 0",
                     alu_a, alu_b, alu_s, alu_c0, alu_il, alu_ir);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_ones();
        run_mul(4'd15, 4'd15, 8'hE1, "15x15");
        for (int i = 0; i < 8; i++) begin
            logic [3:0] want;
            want = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            checks++;
            if (seen_s[i] !== want) begin
                errors++;
                $display("FAIL 15x15 alu_s[%0d]: got %b want %b", i, seen_s[i], want);
            end
        end
    endtask

    task automatic test_mixed_bits();
        logic [3:0] want [0:3];
        want[0] = 4'b0001;
        want[1] = 4'b0001;
        want[2] = 4'b0000;
        want[3] = 4'b0001;
        run_mul(4'd13, 4'd11, 8'h8F, "13x11");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_s[2*i] !== want[i]) begin
                errors++;
                $display("FAIL 13x11 add-op[%0d]: got %b want %b", i, seen_s[2*i], want[i]);
            end
        end
    endtask

    task automatic test_zero();
        run_mul(4'd0, 4'd9, 8'h00, "0x9");
        run_mul(4'd7, 4'd0, 8'h00, "7x0");
    endtask

    task automatic test_ignored_start();
        int done_at;
        int pulses;
        done_at = -1;
        pulses  = 0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = 4'd5;
        mplier = 4'd6;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 6);
            if (start) begin
                mcand  = 4'd15;
                mplier = 4'd15;
            end
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 1 || done_at != 9) begin
            errors++;
            $display("FAIL ignore-start done: got %0d pulses at %0d want 1 at 9", pulses, done_at);
        end
        checks++;
        if (product !== 8'h1E) begin
            errors++;
            $display("FAIL ignore-start product: got %h want 1e", product);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore-start idle busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = 4'd9;
        mplier = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (alu_s !== 4'b1000) begin
            errors++;
            $display("FAIL abort pre-reset SHIFT: got alu_s=%b want 1000", alu_s);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, product, alu_a, alu_b, alu_s, alu_c0, alu_il, alu_ir} !== 25'd0) begin
            errors++;
            $display("FAIL abort in-reset outputs: got busy=%b done=%b product=%h a=%h s=%b ir=%b want 0",
                     busy, done, product, alu_a, alu_s, alu_ir);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort spurious done: got %0d pulses want 0", pulses);
        end
        run_mul(4'd2, 4'd3, 8'h06, "2x3 after abort");
    endtask

    task automatic test_back_to_back();
        int         n;
        int         at   [0:2];
        logic [7:0] prod [0:2];
        logic [7:0] want [0:2];
        n       = 0;
        want[0] = 8'h01;
        want[1] = 8'h0F;
        want[2] = 8'h10;
        for (int k = 0; k < 3; k++) begin
            at[k]   = -1;
            prod[k] = 8'hXX;
        end
        @(negedge clk);
        start  = 1'b1;
        mcand  = 4'd1;
        mplier = 4'd1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (n < 3) begin
                    at[n]   = i;
                    prod[n] = product;
                end
                n++;
                if (n == 1) begin
                    mcand  = 4'd15;
                    mplier = 4'd1;
                end else if (n == 2) begin
                    mcand  = 4'd8;
                    mplier = 4'd2;
                end else begin
                    start  = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b done count: got %0d want 3", n);
        end
        checks++;
        if (at[0] != 9 || at[1] - at[0] != 11 || at[2] - at[1] != 11) begin
            errors++;
            $display("FAIL b2b spacing: got %0d,%0d,%0d want 9,20,31", at[0], at[1], at[2]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (prod[k] !== want[k]) begin
                errors++;
                $display("FAIL b2b product[%0d]: got %h want %h", k, prod[k], want[k]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b final busy: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_ones();
        test_mixed_bits();
        test_zero();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
